// File: rtl/vscale_htif_pcr_arbiter_pkg.sv
// Shared types for the HTIF PCR arbiter: FSM state encoding,
// requester index type, default timeout and a one-hot helper.
`ifndef HTIF_PCR_WIDTH
`define HTIF_PCR_WIDTH 64
`endif

package vscale_htif_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } arb_state_e;

    typedef logic rq_idx_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    function automatic logic [1:0] idx_onehot(input rq_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/vscale_htif_pcr_arbiter_if.sv
// Downstream HTIF PCR request/response channel toward vscale_core.
// master: arbiter side (drives request, accepts response); slave: core side.
interface vscale_htif_pcr_arbiter_if #(
    parameter int PCR_WIDTH  = `HTIF_PCR_WIDTH,
    parameter int ADDR_WIDTH = 12
);
    logic                  pcr_req_valid;
    logic                  pcr_req_ready;
    logic                  pcr_req_rw;
    logic [ADDR_WIDTH-1:0] pcr_req_addr;
    logic [PCR_WIDTH-1:0]  pcr_req_data;
    logic                  pcr_resp_valid;
    logic                  pcr_resp_ready;
    logic [PCR_WIDTH-1:0]  pcr_resp_data;

    modport master (
        output pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data,
        output pcr_resp_ready,
        input  pcr_req_ready, pcr_resp_valid, pcr_resp_data
    );

    modport slave (
        input  pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data,
        input  pcr_resp_ready,
        output pcr_req_ready, pcr_resp_valid, pcr_resp_data
    );
endinterface

// File: rtl/vscale_htif_pcr_arbiter_rr_arb2.sv
// Two-way round-robin grant; last pointer resets to 1 so requester 0
// wins the first contention. Ports: req in, update in, gnt_* out.
module vscale_rr_arb2
    import vscale_htif_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       gnt_any,
    output rq_idx_t    gnt_idx
);
    rq_idx_t last_q;
    rq_idx_t last_d;

    always_comb begin
        gnt_idx = 1'b0;
        unique case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_q;
            default: gnt_idx = 1'b0;
        endcase
        gnt_any = |req;
        last_d  = update ? gnt_idx : last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_q <= 1'b1;
        else          last_q <= last_d;
    end
endmodule

// File: rtl/vscale_htif_pcr_arbiter.sv
// Shares the core HTIF PCR port between the tohost poller (0) and the debug
// host (1): round-robin, one outstanding request, timeout with late-response
// drain. Ports: rq_*/rs_* per requester, pcr (downstream), timeout_seen.
module vscale_htif_pcr_arbiter
    import vscale_htif_arb_pkg::*;
#(
    parameter int PCR_WIDTH      = `HTIF_PCR_WIDTH,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            rq_valid,
    output logic [1:0]            rq_ready,
    input  logic [1:0]            rq_rw,
    input  logic [ADDR_WIDTH-1:0] rq_addr0,
    input  logic [ADDR_WIDTH-1:0] rq_addr1,
    input  logic [PCR_WIDTH-1:0]  rq_data0,
    input  logic [PCR_WIDTH-1:0]  rq_data1,
    output logic [1:0]            rs_valid,
    input  logic [1:0]            rs_ready,
    output logic [1:0]            rs_err,
    output logic [PCR_WIDTH-1:0]  rs_data,
    vscale_htif_pcr_arbiter_if.master pcr,
    output logic                  timeout_seen
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    arb_state_e            state_q, state_d;
    rq_idx_t               owner_q, owner_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PCR_WIDTH-1:0]  wdata_q, wdata_d;
    logic [PCR_WIDTH-1:0]  rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  drain_q, drain_d;
    logic                  ts_q, ts_d;

    logic    gnt_any;
    rq_idx_t gnt_idx;
    logic    accept;

    vscale_rr_arb2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (rq_valid),
        .update  (accept),
        .gnt_any (gnt_any),
        .gnt_idx (gnt_idx)
    );

    // Grant is only offered when idle and no stale response is owed.
    always_comb begin
        rq_ready = 2'b00;
        if (state_q == S_IDLE && !drain_q && gnt_any)
            rq_ready = idx_onehot(gnt_idx);
        accept = |(rq_ready & rq_valid);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        timer_d = timer_q;
        drain_d = drain_q;
        ts_d    = ts_q;

        // First response absorbed while draining is the late one; drop it.
        if (drain_q && pcr.pcr_resp_valid)
            drain_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    owner_d = gnt_idx;
                    rw_d    = rq_rw[gnt_idx];
                    addr_d  = gnt_idx ? rq_addr1 : rq_addr0;
                    wdata_d = gnt_idx ? rq_data1 : rq_data0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (pcr.pcr_req_ready) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response on the expiry cycle beats the timeout.
                if (pcr.pcr_resp_valid) begin
                    rdata_d = pcr.pcr_resp_data;
                    err_d   = 1'b0;
                    state_d = S_DELIVER;
                end else if (timer_q == TIMER_MAX) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    drain_d = 1'b1;
                    ts_d    = 1'b1;
                    state_d = S_DELIVER;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DELIVER: begin
                if (rs_ready[owner_q])
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
            drain_q <= 1'b0;
            ts_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            drain_q <= drain_d;
            ts_q    <= ts_d;
        end
    end

    always_comb begin
        pcr.pcr_req_valid  = (state_q == S_ISSUE);
        pcr.pcr_req_rw     = rw_q;
        pcr.pcr_req_addr   = addr_q;
        pcr.pcr_req_data   = wdata_q;
        pcr.pcr_resp_ready = (state_q == S_WAIT) || drain_q;
        rs_valid = (state_q == S_DELIVER) ? idx_onehot(owner_q) : 2'b00;
        rs_err   = (state_q == S_DELIVER && err_q) ? idx_onehot(owner_q) : 2'b00;
        rs_data      = rdata_q;
        timeout_seen = ts_q;
    end
endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
// Randomized bench for vscale_htif_pcr_arbiter with a transaction-timeline
// reference model plus directed scenarios pinning key latencies.
module tb_vscale_htif_pcr_arbiter;
    localparam int PW = 64;
    localparam int AW = 12;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    rq_valid, rq_ready, rq_rw;
    logic [AW-1:0] rq_addr0, rq_addr1;
    logic [PW-1:0] rq_data0, rq_data1;
    logic [1:0]    rs_valid, rs_ready, rs_err;
    logic [PW-1:0] rs_data;
    logic          timeout_seen;

    always #5 clk = ~clk;

    vscale_htif_pcr_arbiter_if #(.PCR_WIDTH(PW), .ADDR_WIDTH(AW)) pcr ();

    vscale_htif_pcr_arbiter #(
        .PCR_WIDTH(PW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_rw(rq_rw),
        .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
        .rq_data0(rq_data0), .rq_data1(rq_data1),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_err(rs_err),
        .rs_data(rs_data), .pcr(pcr), .timeout_seen(timeout_seen)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Model: each transaction is a timeline fixed at acceptance time.
    bit            busy, to, ts_m;
    int            a, d, L, e, H, W, D, E;
    int            owner, m_last, free_cyc, dr_lo, dr_hi;
    bit            m_rw;
    logic [AW-1:0] m_addr;
    logic [PW-1:0] m_wdata, m_rdata;
    bit   [1:0]    hs;

    bit            dir_en;
    int            dir_left, dir_d, dir_L, dir_e;
    bit   [1:0]    dir_mask;
    logic [PW-1:0] dir_rdata;

    int            first_rs, reqv_cnt;
    logic [1:0]    obs_rsv, obs_err;
    logic [PW-1:0] obs_data;
    int            grants[$];
    int            accs[$];

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     n, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] rr_pick(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic model_reset();
        busy = 0; ts_m = 0; m_last = 1; free_cyc = 0;
        dr_lo = 1; dr_hi = 0; hs = 2'b00;
    endtask

    task automatic compare();
        logic [1:0] g, ex_rsv;
        bit free, ex_reqv, ex_rr;
        g = rr_pick(rq_valid, m_last);
        free = !busy && cyc >= free_cyc;
        chk("rq_ready", rq_ready, free ? g : 2'b00);
        ex_reqv = busy && cyc >= a + 1 && cyc <= H;
        chk("pcr_req_valid", pcr.pcr_req_valid, ex_reqv);
        if (ex_reqv) begin
            chk("pcr_req_rw", pcr.pcr_req_rw, m_rw);
            chk("pcr_req_addr", pcr.pcr_req_addr, m_addr);
            chk("pcr_req_data", pcr.pcr_req_data, m_wdata);
        end
        ex_rr = (busy && cyc >= H + 1 && cyc <= H + 1 + W) ||
                (cyc >= dr_lo && cyc <= dr_hi);
        chk("pcr_resp_ready", pcr.pcr_resp_ready, ex_rr);
        ex_rsv = (busy && cyc >= D) ? (owner ? 2'b10 : 2'b01) : 2'b00;
        chk("rs_valid", rs_valid, ex_rsv);
        chk("rs_err", rs_err, to ? ex_rsv : 2'b00);
        if (ex_rsv != 0)
            chk("rs_data", rs_data, to ? '0 : m_rdata);
        chk("timeout_seen", timeout_seen, ts_m || (busy && to && cyc >= D));
        if (rs_valid != 0 && first_rs < 0) begin
            first_rs = cyc; obs_rsv = rs_valid;
            obs_err = rs_err; obs_data = rs_data;
        end
        if (pcr.pcr_req_valid) reqv_cnt++;
        if ((rq_valid & rq_ready) == 2'b01) grants.push_back(0);
        if ((rq_valid & rq_ready) == 2'b10) grants.push_back(1);
    endtask

    task automatic advance();
        logic [1:0] g;
        g = rr_pick(rq_valid, m_last);
        if (busy && cyc == E) begin
            busy = 0;
            free_cyc = cyc + 1;
            if (to && dr_hi + 1 > free_cyc) free_cyc = dr_hi + 1;
            if (to) ts_m = 1;
        end else if (!busy && cyc >= free_cyc && g != 0) begin
            busy = 1; a = cyc; owner = g[1] ? 1 : 0; m_last = owner;
            hs[owner] = 1'b1; accs.push_back(cyc);
            m_rw = rq_rw[owner];
            m_addr = owner ? rq_addr1 : rq_addr0;
            m_wdata = owner ? rq_data1 : rq_data0;
            if (dir_en) begin
                d = dir_d; L = dir_L; e = dir_e; m_rdata = dir_rdata;
                if (dir_left > 0) dir_left--;
            end else begin
                d = $urandom_range(0, 3);
                L = ($urandom_range(0, 3) == 0) ?
                    $urandom_range(T - 2, T + 5) : $urandom_range(0, 5);
                e = $urandom_range(0, 2);
                m_rdata = {$urandom, $urandom};
            end
            H = a + 1 + d;
            to = (L >= T);
            W = to ? T - 1 : L;
            D = H + 2 + W;
            E = D + e;
            if (to) begin
                dr_lo = H + 1 + T; dr_hi = H + 1 + L;
            end
        end
    endtask

    task automatic drive();
        bit late;
        late = (cyc == dr_hi && dr_hi >= dr_lo);
        pcr.pcr_req_ready = busy && cyc == H;
        pcr.pcr_resp_valid = (busy && !to && cyc == H + 1 + L) || late;
        pcr.pcr_resp_data = (busy && !to && !late) ? m_rdata : {$urandom, $urandom};
        rs_ready = 2'($urandom_range(0, 3));
        rs_ready[owner] = busy && cyc == E;
        for (int i = 0; i < 2; i++) begin
            if (dir_en) begin
                rq_valid[i] = (dir_left > 0) && dir_mask[i];
            end else if (!rq_valid[i] || hs[i]) begin
                rq_valid[i] = 1'($urandom_range(0, 1));
                rq_rw[i] = 1'($urandom_range(0, 1));
                if (i == 0) begin
                    rq_addr0 = AW'($urandom); rq_data0 = {$urandom, $urandom};
                end else begin
                    rq_addr1 = AW'($urandom); rq_data1 = {$urandom, $urandom};
                end
            end
        end
        hs = 2'b00;
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        advance();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rq_valid = 2'b00; rs_ready = 2'b00;
        pcr.pcr_req_ready = 1'b0; pcr.pcr_resp_valid = 1'b0;
        pcr.pcr_resp_data = '0;
        #1;
        chk("rst_rq_ready", rq_ready, 2'b00);
        chk("rst_req_valid", pcr.pcr_req_valid, 1'b0);
        chk("rst_resp_ready", pcr.pcr_resp_ready, 1'b0);
        chk("rst_rs_valid", rs_valid, 2'b00);
        chk("rst_rs_err", rs_err, 2'b00);
        chk("rst_rs_data", rs_data, '0);
        chk("rst_req_addr", pcr.pcr_req_addr, '0);
        chk("rst_req_data", pcr.pcr_req_data, '0);
        chk("rst_timeout_seen", timeout_seen, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        drive();
    endtask

    task automatic dir_setup(input bit [1:0] mask, input int n,
                             input int dd, input int ll, input int ee,
                             input logic [PW-1:0] rd);
        dir_en = 1; dir_mask = mask; dir_left = n;
        dir_d = dd; dir_L = ll; dir_e = ee; dir_rdata = rd;
        first_rs = -1; reqv_cnt = 0;
        grants.delete(); accs.delete();
    endtask

    initial begin
        bit in_wait;
        rq_valid = 2'b00; rq_rw = 2'b00;
        rq_addr0 = '0; rq_addr1 = '0; rq_data0 = '0; rq_data1 = '0;
        owner = 0; H = 0; L = 0; to = 0;
        dir_en = 1; dir_left = 0;
        do_reset();

        // Single read from requester 0, response two WAIT cycles later.
        rq_rw[0] = 1'b0; rq_addr0 = 12'h780; rq_data0 = '0;
        dir_setup(2'b01, 1, 0, 2, 0, 64'h1);
        run(15);
        chk("rd0_latency", 64'(first_rs - accs[0]), 64'd5);
        chk("rd0_owner", obs_rsv, 2'b01);
        chk("rd0_data", obs_data, 64'h1);
        chk("rd0_err", obs_err, 2'b00);

        // Both requesters valid from reset: grants alternate 0,1,0,1.
        do_reset();
        dir_setup(2'b11, 4, 0, 0, 0, 64'h55);
        run(30);
        chk("rr_count", 64'(grants.size()), 64'd4);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            chk($sformatf("rr_grant%0d", k), 64'(grants[k]), 64'(k % 2));

        // Write from requester 1 with the core stalling the request.
        rq_rw[1] = 1'b1; rq_addr1 = 12'h51E; rq_data1 = 64'hDEAD_BEEF;
        dir_setup(2'b10, 1, 5, 1, 0, 64'h0);
        run(20);
        chk("wr_req_hold", 64'(reqv_cnt), 64'd6);

        // Timeout with a late response; the next request waits for it.
        rq_rw[0] = 1'b0; rq_addr0 = 12'h300;
        dir_setup(2'b11, 2, 0, 13, 0, 64'h9);
        run(60);
        chk("to_latency", 64'(first_rs - accs[0]), 64'd10);
        chk("to_err", obs_err, 2'b01);
        chk("to_data", obs_data, '0);
        chk("to_sticky", timeout_seen, 1'b1);
        chk("to_next_accept", 64'(accs.size() > 1 ? accs[1] - accs[0] : 0),
            64'd16);

        // Response lands exactly on the expiry cycle.
        dir_setup(2'b01, 1, 0, T - 1, 0, 64'h1234);
        run(20);
        chk("exp_latency", 64'(first_rs - accs[0]), 64'd10);
        chk("exp_err", obs_err, 2'b00);
        chk("exp_data", obs_data, 64'h1234);

        // Reset while waiting on the core, then a normal transaction.
        dir_setup(2'b01, 1, 0, 12, 0, 64'h0);
        in_wait = 0;
        for (int k = 0; k < 50 && !in_wait; k++) begin
            step();
            in_wait = busy && cyc >= H + 1 && cyc <= H + 1 + W;
        end
        chk("wait_reached", in_wait, 1'b1);
        #2;
        do_reset();
        dir_setup(2'b01, 1, 0, 0, 0, 64'hABC);
        run(12);
        chk("post_rst_latency", 64'(first_rs - accs[0]), 64'd3);
        chk("post_rst_data", obs_data, 64'hABC);

        // Randomized traffic against the timeline model.
        dir_en = 0;
        first_rs = 0;
        run(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vscale_htif_pcr_arbiter.md
# vscale_htif_pcr_arbiter

Shares the single HTIF PCR request/response port of `vscale_core` between two host-side requesters: requester 0 is the tohost poller, requester 1 is the interactive debug host. It does round-robin arbitration with one outstanding transaction, registers the captured request, and routes the response back to the owning requester. A response timeout returns an error to the requester instead of hanging it, and the late response is drained and discarded. The block sits between the simulation/host harness and the `htif_pcr_*` pins of `vscale_sim_top`.

## Interface
- `PCR_WIDTH`, default `` `HTIF_PCR_WIDTH `` (64): data width.
- `ADDR_WIDTH`, default 12: CSR address width.
- `TIMEOUT_CYCLES`, default 256: cycles spent in RESP before an error is returned (≥2).

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rq_valid[1:0]`, `rq_ready[1:0]`, `rq_rw[1:0]`: per-requester request handshake and write flag (in/out/in).
- `rq_addr0`/`rq_addr1` in ADDR_WIDTH; `rq_data0`/`rq_data1` in PCR_WIDTH.
- `rs_valid[1:0]` out, `rs_ready[1:0]` in, `rs_err[1:0]` out: per-requester response handshake and error flag.
- `rs_data` out PCR_WIDTH: shared response data, qualified by `rs_valid[i]`.
- `pcr_req_valid` out 1, `pcr_req_ready` in 1, `pcr_req_rw` out 1, `pcr_req_addr` out ADDR_WIDTH, `pcr_req_data` out PCR_WIDTH: downstream request.
- `pcr_resp_valid` in 1, `pcr_resp_ready` out 1, `pcr_resp_data` in PCR_WIDTH: downstream response.
- `timeout_seen` out 1: sticky; set on any timeout, cleared only by reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- **IDLE:** if `drain`=0 and any `rq_valid`, grant one requester.
  - If both are valid, grant the one ≠ `last`.
  - `rq_ready[g]`=1 combinationally for the granted requester only.
  - On the handshake, latch owner, rw, addr and data, set `last`=g, and go to ISSUE.
  - While `drain`=1, `rq_ready`=0.
- **ISSUE:** `pcr_req_valid`=1 with the latched fields held stable. On `pcr_req_ready`, go to WAIT and clear the timer.
- **WAIT:** `pcr_resp_ready`=1.
  - On `pcr_resp_valid`, latch data, set err=0, go to DELIVER.
  - Otherwise increment the timer. At `TIMEOUT_CYCLES`-1 with no response: latch data=0, set err=1, `drain`=1, `timeout_seen`=1, go to DELIVER.
- **DELIVER:** `rs_valid[owner]`=1, with `rs_data` and `rs_err[owner]` stable. On `rs_ready[owner]`, go to IDLE.
- **Drain:** `pcr_resp_ready`=1 in every state while `drain`=1. The first downstream response absorbed while `drain`=1 is discarded and clears `drain`. If the core never responds, the arbiter stays blocked; this is intended, and `timeout_seen` flags it.
- Response timing: a response arriving in the same cycle the timer expires is taken as a normal response (err=0); the response wins over the timeout.
- Reset mid-operation: the transaction is abandoned. No response is produced and the FSM returns to IDLE.

## Timing
- Reset values:
  - state IDLE, `last`=1 (requester 0 favoured first), `drain`=0, timer 0, `timeout_seen`=0.
  - All `*_valid`/`*_ready` outputs 0 except the combinational `rq_ready` in IDLE.
  - `rs_data`, `pcr_req_addr`, `pcr_req_data` = 0.
- Latency from the request handshake (cycle N):
  - `pcr_req_valid` at N+1.
  - With zero-wait ready and response, `rs_valid` at N+3.
  - The next grant is possible in the cycle after the `rs_ready` handshake.
- Only `rq_ready` depends combinationally on inputs (`rq_valid`, `drain`, state). All other outputs are decoded from registers.
- Timer width is `$clog2(TIMEOUT_CYCLES)`. It saturates and never wraps.

## Structure
- `vscale_htif_arb_pkg`: FSM state enum (2 bits), requester index type, and the default `TIMEOUT_CYCLES` constant. `HTIF_PCR_WIDTH` stays in the existing control constants header.
- One natural sub-module: `vscale_rr_arb2`, a 2-way round-robin grant with the `last` pointer and an update enable.
- The FSM, request/response holding registers, timer and drain flag live in the top.

## Test plan
- Single read from requester 0, addr 0x780, core responds 0x1 after 2 cycles → `rs_valid[0]` with data 0x1, err=0; `rs_valid[1]` stays 0.
- Both requesters valid from reset → requester 0 granted first and requester 1 second. With both held valid, grants alternate 0,1,0,1 over 4 transactions.
- Write from requester 1, data 0xDEAD_BEEF, addr 0x51E, `pcr_req_ready` low for 5 cycles → request fields are held stable all 5 cycles and `pcr_req_rw`=1.
- `TIMEOUT_CYCLES`=8 with no response → `rs_err[owner]`=1, data 0, `timeout_seen`=1. A response injected at cycle 20 is discarded. Requests are blocked until then and accepted the cycle after.
- Response arrives on the exact expiry cycle → err=0, correct data, `drain` stays 0.
- `reset_n` asserted during WAIT → all outputs return to reset values immediately, and the next request is granted normally after release.
